// File: rtl/pipelined_shifter.sv
// pipelined_shifter
// -----------------------------------------------------------------------------
// Parametrised, fully pipelined barrel shifter for the ALU shift datapath.
// A WIDTH-bit operand is shifted by an unsigned amount 0..WIDTH-1 in one of
// four modes (SLL, SRL, SRA, ROR). Each pipeline stage resolves one bit of the
// shift amount, most significant bit first, so stage 0 shifts by WIDTH/2 and
// the last stage shifts by 1. A valid/ready handshake on both sides lets the
// whole pipeline freeze behind a busy consumer.
//
// Optional feature macro: PIPELINED_SHIFTER_ROTATE_EN
//    defined   : in_op = 2'b11 rotates right (ROR)
//    undefined : in_op = 2'b11 behaves exactly like SRL, no rotate logic built
//
// Parameters
//    WIDTH     data width, must equal 2**SHAMT_W
//    SHAMT_W   shift-amount width, also the number of pipeline stages
//
// Ports
//    clock      system clock, rising edge
//    reset      synchronous active-high reset
//    in_valid   input transfer offered
//    in_ready   pipeline can accept an input this cycle (combinational)
//    in_data    operand
//    in_shamt   unsigned shift amount
//    in_op      00 SLL, 01 SRL, 10 SRA, 11 ROR
//    out_valid  out_data holds a result
//    out_ready  consumer accepts the result
//    out_data   shifted result, registered
// -----------------------------------------------------------------------------
module pipelined_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data
);

   // Operation encoding shared by every stage.
   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } shiftOp_e;

   // Per-stage pipeline registers and their next-state values.
   logic [SHAMT_W-1:0] stageValid_q;
   logic [SHAMT_W-1:0] stageValid_d;
   logic [WIDTH-1:0]   stageData_q  [SHAMT_W];
   logic [WIDTH-1:0]   stageData_d  [SHAMT_W];
   logic [SHAMT_W-1:0] stageShamt_q [SHAMT_W];
   logic [SHAMT_W-1:0] stageShamt_d [SHAMT_W];
   logic [1:0]         stageOp_q    [SHAMT_W];
   logic [1:0]         stageOp_d    [SHAMT_W];

   // What each stage sees at its input: stage 0 takes the ports directly,
   // every later stage takes the register of the stage before it.
   logic               srcValid [SHAMT_W];
   logic [WIDTH-1:0]   srcData  [SHAMT_W];
   logic [SHAMT_W-1:0] srcShamt [SHAMT_W];
   logic [1:0]         srcOp    [SHAMT_W];

   logic adv;

   // One fixed-distance shift in the selected mode. The distance is a
   // constant per stage once the stage loop is unrolled, so each stage is
   // just a 2:1 choice of wiring plus a small mode mux. For SRA the current
   // MSB is replicated; earlier stages never change the MSB, so this is
   // always the sign of the original operand.
   function automatic logic [WIDTH-1:0] shiftBy(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       op,
      input int unsigned      amt
   );
      shiftBy = d >> amt;
      case (shiftOp_e'(op))
         OP_SLL: shiftBy = d << amt;
         OP_SRL: shiftBy = d >> amt;
         OP_SRA: shiftBy = $unsigned($signed(d) >>> amt);
         OP_ROR: begin
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            shiftBy = (d >> amt) | (d << (WIDTH - amt));
`else
            shiftBy = d >> amt;
`endif
         end
         default: shiftBy = d >> amt;
      endcase
   endfunction

   // The pipeline advances as a whole unless a finished result is sitting
   // at the output with nobody taking it. There is no bubble squeezing, so
   // a single enable is enough and in_ready is simply that enable.
   always_comb begin
      adv       = !(out_valid && !out_ready);
      in_ready  = adv;
      out_valid = stageValid_q[SHAMT_W-1];
      out_data  = stageData_q[SHAMT_W-1];
   end

   // Route each stage's source: ports for stage 0, previous register after.
   always_comb begin
      for (int i = 0; i < SHAMT_W; i++) begin
         if (i == 0) begin
            srcValid[i] = in_valid;
            srcData[i]  = in_data;
            srcShamt[i] = in_shamt;
            srcOp[i]    = in_op;
         end else begin
            srcValid[i] = stageValid_q[i-1];
            srcData[i]  = stageData_q[i-1];
            srcShamt[i] = stageShamt_q[i-1];
            srcOp[i]    = stageOp_q[i-1];
         end
      end
   end

   // Next-state for every stage. Stage i looks at shamt bit SHAMT_W-1-i and,
   // when set, shifts by 2**(SHAMT_W-1-i). Shamt and op ride along with the
   // data so later stages know what to do.
   always_comb begin
      stageValid_d = '0;
      for (int i = 0; i < SHAMT_W; i++) begin
         stageValid_d[i] = srcValid[i];
         stageShamt_d[i] = srcShamt[i];
         stageOp_d[i]    = srcOp[i];
         if (srcShamt[i][SHAMT_W-1-i]) begin
            stageData_d[i] = shiftBy(srcData[i], srcOp[i], 1 << (SHAMT_W-1-i));
         end else begin
            stageData_d[i] = srcData[i];
         end
      end
   end

   // Stage registers. Reset clears everything, which also throws away any
   // results still in flight. With adv low every stage holds, so a stalled
   // result stays stable at the output and nothing behind it is lost.
   always_ff @(posedge clock) begin
      if (reset) begin
         stageValid_q <= '0;
         for (int i = 0; i < SHAMT_W; i++) begin
            stageData_q[i]  <= '0;
            stageShamt_q[i] <= '0;
            stageOp_q[i]    <= '0;
         end
      end else if (adv) begin
         stageValid_q <= stageValid_d;
         for (int i = 0; i < SHAMT_W; i++) begin
            stageData_q[i]  <= stageData_d[i];
            stageShamt_q[i] <= stageShamt_d[i];
            stageOp_q[i]    <= stageOp_d[i];
         end
      end
   end

endmodule
